rca_accumulator: RTL and testbench
==================================

Name: rca_accumulator

Overview:
- Sequential stage directly downstream of RippleCarryAdder; sums a burst of Length unsigned operands into a registered running total.
- Uses one internal RippleCarryAdder #(AccWidth) instance for every addition.
- Operands arrive over a valid/ready handshake; the result leaves over a second valid/ready handshake.
- Sits between an operand source and any consumer of summed totals.

Parameters:
- InputWidth, 4, width of each incoming unsigned operand.
- AccWidth, 8, width of the accumulator and Total; must be at least InputWidth.
- CountWidth, 5, width of Length; bursts hold 0 to 2^CountWidth-1 operands.

Ports:
- Clk  input  1  single clock; all state changes on its rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle request to begin a burst; honoured only in IDLE.
- Length  input  CountWidth  operand count, sampled when Start is honoured.
- InValid  input  1  InData is valid.
- InReady  output  1  block accepts an operand this cycle.
- InData  input  InputWidth  operand, zero-extended to AccWidth.
- OutValid  output  1  Total and Overflow hold the final result.
- OutReady  input  1  consumer takes the result.
- Total  output  AccWidth  accumulated sum, modulo 2^AccWidth.
- Overflow  output  1  sticky flag: at least one addition in the burst produced a carry out.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Rst asserted, asynchronously: state=IDLE; Total=0, Overflow=0, OutValid=0, InReady=0, Busy=0; internal remaining-count=0. Reset mid-burst discards the burst with no output.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.
- States:
  - IDLE
    - Start=1 and Length>0: Total<=0, Overflow<=0, remaining<=Length, go to ACCUM.
    - Start=1 and Length=0: Total<=0, Overflow<=0, go to DONE.
    - Start=0: stay.
  - ACCUM: InReady=1, Busy=1.
    - Acceptance happens on any cycle with InValid=1.
    - On acceptance: the adder computes Total + {0, InData}. Total<=Sum[AccWidth-1:0]; Overflow<=Overflow | Sum[AccWidth]; remaining decrements.
    - If remaining was 1 on acceptance: go to DONE.
    - InValid=0 cycles (gaps): no change.
  - DONE: OutValid=1, InReady=0, Busy=1; Total and Overflow held stable.
    - OutReady=1: go to IDLE next cycle; OutValid drops that cycle; Total and Overflow keep their values until the next honoured Start.
- Start is ignored in ACCUM and DONE. Length is sampled only with an honoured Start.
- Latency: OutValid rises on the cycle after the last operand is accepted. A Length=0 burst gives OutValid on the cycle after Start.
- Throughput: one operand per cycle. Minimum burst period is Length+2 cycles (one ACCUM entry, Length accepts, one DONE cycle with OutReady=1).
- Wrap-around: the accumulator wraps modulo 2^AccWidth and keeps adding after the wrap. Overflow stays set until the next honoured Start.
- InData arriving in IDLE or DONE is not accepted (InReady=0) and has no effect.

Test Plan:
- Start, Length=3; operands 5, 2, 9 on consecutive cycles -> OutValid on the cycle after 9 is accepted; Total=16 (0x10), Overflow=0; InReady drops in DONE.
- Start, Length=18; eighteen operands of 15 (sum 270) -> Total=14 (0x0E), Overflow=1; carry first set on operand 18. Next burst of Length=1, operand 3 -> Total=3, Overflow=0.
- Start, Length=0 -> OutValid=1 the next cycle with Total=0, Overflow=0; InReady never asserts.
- Length=4, operands 1, 2, 3, 4 with InValid low for two cycles between each -> Total=10; remaining decrements only on accepts.
- Backpressure: result ready (Total=16), OutReady low 5 cycles, Start pulsed with Length=2 during DONE -> Total stable, Start ignored; OutReady=1 returns to IDLE, OutValid=0, Busy=0.
- Rst pulsed mid-burst after 2 of 5 operands -> all outputs 0 and state IDLE immediately, without waiting for Clk. A fresh Start, Length=1, operand 7 -> Total=7.

Source files
------------

// File: rtl/rca_accumulator.sv
// rtl/rca_accumulator.sv - burst accumulator built around a ripple-carry adder

// One-bit full adder cell used to build the ripple chain.
module rca_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  // Sum and carry of three input bits.
  always_comb begin
    o_sum  = i_a ^ i_b ^ i_cin;
    o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
  end

endmodule

// Width-bit ripple-carry adder; Sum carries the final carry out in its MSB.
module RippleCarryAdder #(
  parameter int Width = 8
) (
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic             Cin,
  output logic [Width:0]   Sum
);

  logic [Width:0]   w_carry;
  logic [Width-1:0] w_bits;

  assign w_carry[0] = Cin;

  genvar g;
  generate
    for (g = 0; g < Width; g++) begin : g_bit
      rca_full_adder u_fa (
        .i_a   (A[g]),
        .i_b   (B[g]),
        .i_cin (w_carry[g]),
        .o_sum (w_bits[g]),
        .o_cout(w_carry[g+1])
      );
    end
  endgenerate

  assign Sum = {w_carry[Width], w_bits};

endmodule

// Sums a burst of Length operands; result leaves on a valid/ready handshake.
module rca_accumulator #(
  parameter int InputWidth = 4,
  parameter int AccWidth   = 8,
  parameter int CountWidth = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [CountWidth-1:0] Length,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [InputWidth-1:0] InData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [AccWidth-1:0]   Total,
  output logic                  Overflow,
  output logic                  Busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [AccWidth-1:0]   r_total;
  logic                  r_overflow;
  logic [CountWidth-1:0] r_remaining;

  logic [AccWidth-1:0]   w_operand;
  logic [AccWidth:0]     w_sum;
  logic                  w_start_ok;
  logic                  w_accept;
  logic                  w_last;

  // Operand is zero-extended so the adder always works at accumulator width.
  assign w_operand = AccWidth'(InData);

  RippleCarryAdder #(
    .Width(AccWidth)
  ) u_adder (
    .A  (r_total),
    .B  (w_operand),
    .Cin(1'b0),
    .Sum(w_sum)
  );

  // Start only counts in IDLE; operands only count in ACCUM.
  assign w_start_ok = (r_state == S_IDLE) && Start;
  assign w_accept   = (r_state == S_ACCUM) && InValid;
  assign w_last     = w_accept && (r_remaining == CountWidth'(1));

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_next_state = (Length == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (OutReady) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Running total, sticky carry flag and operands still to come.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_total     <= '0;
      r_overflow  <= 1'b0;
      r_remaining <= '0;
    end else if (w_start_ok) begin
      r_total     <= '0;
      r_overflow  <= 1'b0;
      r_remaining <= Length;
    end else if (w_accept) begin
      r_total     <= w_sum[AccWidth-1:0];
      r_overflow  <= r_overflow | w_sum[AccWidth];
      r_remaining <= r_remaining - CountWidth'(1);
    end
  end

  // Handshake and status outputs decode straight from state.
  always_comb begin
    InReady  = (r_state == S_ACCUM);
    OutValid = (r_state == S_DONE);
    Busy     = (r_state != S_IDLE);
  end

  assign Total    = r_total;
  assign Overflow = r_overflow;

endmodule

// File: tb/tb_rca_accumulator.sv
// tb/tb_rca_accumulator.sv - self-checking bench for rca_accumulator

module tb_rca_accumulator;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic [4:0] Length = '0;
  logic       InValid = 1'b0;
  logic       InReady;
  logic [3:0] InData = '0;
  logic       OutValid;
  logic       OutReady = 1'b0;
  logic [7:0] Total;
  logic       Overflow;
  logic       Busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] op_buf [0:31];

  typedef struct {
    int         len;
    int         base;
    int         step;
    int         gap;
    logic [7:0] exp_total;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [0:7];

  rca_accumulator #(
    .InputWidth(4),
    .AccWidth  (8),
    .CountWidth(5)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Length  (Length),
    .InValid (InValid),
    .InReady (InReady),
    .InData  (InData),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Total   (Total),
    .Overflow(Overflow),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one burst from op_buf; gap<0 means random gaps; poke pulses Start during DONE.
  task automatic run_burst(input int len, input int gap, input int hold, input bit poke,
                           input logic [7:0] et, input logic eo, input string tag);
    int g;
    Start  = 1'b1;
    Length = 5'(len);
    @(posedge Clk); #1;
    Start = 1'b0;
    check({tag, " busy after start"}, Busy, 1);
    if (len == 0) check({tag, " inready len0"}, InReady, 0);
    for (int i = 0; i < len; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) begin
        InValid = 1'b0;
        @(posedge Clk); #1;
        check({tag, " inready in gap"}, InReady, 1);
        check({tag, " no outvalid in gap"}, OutValid, 0);
      end
      check({tag, " inready before accept"}, InReady, 1);
      InValid = 1'b1;
      InData  = op_buf[i];
      @(posedge Clk); #1;
      InValid = 1'b0;
      InData  = 4'($urandom);
    end
    check({tag, " outvalid latency"}, OutValid, 1);
    check({tag, " inready in done"}, InReady, 0);
    check({tag, " total"}, Total, et);
    check({tag, " overflow"}, Overflow, eo);
    for (int k = 0; k < hold; k++) begin
      OutReady = 1'b0;
      InValid  = 1'b1;
      InData   = 4'hF;
      if (poke && k == 1) begin
        Start  = 1'b1;
        Length = 5'd2;
      end
      @(posedge Clk); #1;
      Start   = 1'b0;
      InValid = 1'b0;
      check({tag, " outvalid held"}, OutValid, 1);
      check({tag, " total held"}, Total, et);
    end
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    check({tag, " outvalid after take"}, OutValid, 0);
    check({tag, " busy after take"}, Busy, 0);
    check({tag, " total kept in idle"}, Total, et);
    check({tag, " overflow kept in idle"}, Overflow, eo);
  endtask

  initial begin
    int sum;
    int len;

    vecs[0] = '{18, 15, 0, 0, 8'h0E, 1'b1};
    vecs[1] = '{1,  3,  0, 0, 8'h03, 1'b0};
    vecs[2] = '{0,  0,  0, 0, 8'h00, 1'b0};
    vecs[3] = '{4,  1,  1, 2, 8'h0A, 1'b0};
    vecs[4] = '{31, 15, 0, 0, 8'hD1, 1'b1};
    vecs[5] = '{16, 0,  1, 0, 8'h78, 1'b0};
    vecs[6] = '{20, 8,  0, 1, 8'hA0, 1'b0};
    vecs[7] = '{17, 15, 0, 0, 8'hFF, 1'b0};

    #2;
    check("reset total", Total, 0);
    check("reset overflow", Overflow, 0);
    check("reset outvalid", OutValid, 0);
    check("reset inready", InReady, 0);
    check("reset busy", Busy, 0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;

    // Basic burst 5,2,9 with no backpressure.
    op_buf[0] = 4'd5; op_buf[1] = 4'd2; op_buf[2] = 4'd9;
    run_burst(3, 0, 0, 1'b0, 8'h10, 1'b0, "b529");

    // Same burst, result held for five cycles with a Start pulse during DONE.
    run_burst(3, 0, 5, 1'b1, 8'h10, 1'b0, "backpressure");

    // Table of bursts.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].len; i++) op_buf[i] = 4'(vecs[v].base + vecs[v].step * i);
      run_burst(vecs[v].len, vecs[v].gap, 1, 1'b0, vecs[v].exp_total, vecs[v].exp_ovf,
                $sformatf("vec%0d", v));
    end

    // Reset in the middle of a five-operand burst.
    Start = 1'b1; Length = 5'd5;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      InValid = 1'b1; InData = 4'd6;
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check("midreset total", Total, 0);
    check("midreset overflow", Overflow, 0);
    check("midreset outvalid", OutValid, 0);
    check("midreset inready", InReady, 0);
    check("midreset busy", Busy, 0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;
    op_buf[0] = 4'd7;
    run_burst(1, 0, 0, 1'b0, 8'h07, 1'b0, "after reset");

    // Random bursts against a plain-arithmetic model.
    for (int t = 0; t < 25; t++) begin
      len = int'($urandom_range(0, 31));
      sum = 0;
      for (int i = 0; i < len; i++) begin
        op_buf[i] = 4'($urandom);
        sum += int'(op_buf[i]);
      end
      run_burst(len, -1, int'($urandom_range(0, 3)), 1'($urandom), 8'(sum % 256), (sum >= 256),
                $sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
